interrupt_sequencer: RTL and testbench

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

---
 rtl/intseq_pkg.sv | 14 +
 rtl/intseq_irq_stack.sv | 35 +++
 rtl/interrupt_sequencer.sv | 119 +++++++++++
 tb/tb_interrupt_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/intseq_pkg.sv
// Shared constants and FSM state encoding for the interrupt sequencer.
package intseq_pkg;

  localparam int IRQ_W     = 4;
  localparam int VEC_SHIFT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_REQ   = 2'd2,
    ST_ISR   = 2'd3
  } intseq_state_e;

endpackage

// File: rtl/intseq_irq_stack.sv
// Two-entry LIFO holding preempted handler IRQ numbers; only built with INTSEQ_NEST_EN.
module intseq_irq_stack
  import intseq_pkg::*;
(
  input  logic             CLK,
  input  logic             RSTb,
  input  logic             push,
  input  logic             pop,
  input  logic [IRQ_W-1:0] push_irq,
  output logic [IRQ_W-1:0] top,
  output logic [1:0]       depth
);

  logic [IRQ_W-1:0] entry [2];

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      depth <= 2'd0;
    end else if (push && (depth != 2'd2)) begin
      depth <= depth + 2'd1;
    end else if (pop && (depth != 2'd0)) begin
      depth <= depth - 2'd1;
    end
  end

  // Entry storage is pure data; emptiness is tracked by depth alone.
  always_ff @(posedge CLK) begin
    if (push && (depth != 2'd2)) begin
      entry[depth[0]] <= push_irq;
    end
  end

  assign top = (depth == 2'd2) ? entry[1] : entry[0];

endmodule

// File: rtl/interrupt_sequencer.sv
// Takes a prioritised IRQ at an instruction boundary, presents its vector and tracks the
// active handler. Define INTSEQ_NEST_EN to allow one level of higher-priority preemption.
module interrupt_sequencer
  import intseq_pkg::*;
#(
  parameter int             BITS        = 16,
  parameter logic [BITS-1:0] VECTOR_BASE = '0
) (
  input  logic             CLK,
  input  logic             RSTb,
  input  logic             interrupt,
  input  logic [IRQ_W-1:0] irq,
  input  logic             gie,
  input  logic             insn_boundary,
  input  logic             ack,
  input  logic             reti,
  output logic             int_req,
  output logic [BITS-1:0]  vector,
  output logic             in_isr,
  output logic [IRQ_W-1:0] active_irq
);

  intseq_state_e    state;
  logic [IRQ_W-1:0] cand_irq;
  logic             req_valid;
  logic             last_level;
  logic             nest_take;
  logic [IRQ_W-1:0] prev_irq;

  function automatic logic [BITS-1:0] vec_of(input logic [IRQ_W-1:0] n);
    logic [BITS-1:0] off;
    off = BITS'(n) << VEC_SHIFT;
    return VECTOR_BASE + off;
  endfunction

  assign req_valid = interrupt && gie && (irq != '0);

`ifdef INTSEQ_NEST_EN
  logic       stk_push;
  logic       stk_pop;
  logic [1:0] stk_depth;

  // The preempted handler is saved only when an ack arrives while one is already running.
  assign stk_push = (state == ST_REQ) && ack && in_isr;
  assign stk_pop  = (state == ST_ISR) && reti && (stk_depth != 2'd0);

  intseq_irq_stack u_stack (
    .CLK      (CLK),
    .RSTb     (RSTb),
    .push     (stk_push),
    .pop      (stk_pop),
    .push_irq (active_irq),
    .top      (prev_irq),
    .depth    (stk_depth)
  );

  assign last_level = (stk_depth == 2'd0);
  assign nest_take  = req_valid && insn_boundary && (irq < active_irq) && (stk_depth == 2'd0);
`else
  assign last_level = 1'b1;
  assign prev_irq   = '0;
  assign nest_take  = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state      <= ST_IDLE;
      int_req    <= 1'b0;
      vector     <= VECTOR_BASE;
      in_isr     <= 1'b0;
      active_irq <= '0;
      cand_irq   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (!req_valid) begin
            state <= ST_IDLE;
          end else if (insn_boundary) begin
            state    <= ST_REQ;
            cand_irq <= irq;
            vector   <= vec_of(irq);
            int_req  <= 1'b1;
          end
        end
        ST_REQ: begin
          // Completion always uses the latched candidate, whatever irq is doing now.
          if (ack) begin
            state      <= ST_ISR;
            active_irq <= cand_irq;
            in_isr     <= 1'b1;
            int_req    <= 1'b0;
          end
        end
        ST_ISR: begin
          if (reti) begin
            if (last_level) begin
              state      <= ST_IDLE;
              active_irq <= '0;
              in_isr     <= 1'b0;
              vector     <= VECTOR_BASE;
            end else begin
              active_irq <= prev_irq;
            end
          end else if (nest_take) begin
            state    <= ST_REQ;
            cand_irq <= irq;
            vector   <= vec_of(irq);
            int_req  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: table of per-cycle vectors plus hand-written corner sequences.
module tb_interrupt_sequencer;

  typedef struct packed {
    logic        rstb;
    logic        intr;
    logic [3:0]  irq;
    logic        gie;
    logic        bnd;
    logic        ack;
    logic        reti;
    logic        req;
    logic [15:0] vec;
    logic        isr;
    logic [3:0]  act;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RSTb;
  logic        interrupt, gie, insn_boundary, ack, reti;
  logic [3:0]  irq;
  logic        int_req, in_isr;
  logic [15:0] vector;
  logic [3:0]  active_irq;
  logic        w_int_req, w_in_isr;
  logic [5:0]  w_vector;
  logic [3:0]  w_active_irq;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t sb[$];
  vec_t tbl[$];

  always #5 CLK = ~CLK;

  interrupt_sequencer #(.BITS(16), .VECTOR_BASE(16'h0000)) dut (
    .CLK(CLK), .RSTb(RSTb), .interrupt(interrupt), .irq(irq), .gie(gie),
    .insn_boundary(insn_boundary), .ack(ack), .reti(reti),
    .int_req(int_req), .vector(vector), .in_isr(in_isr), .active_irq(active_irq)
  );

  // Narrow instance with a high base so that vector arithmetic wraps modulo 64.
  interrupt_sequencer #(.BITS(6), .VECTOR_BASE(6'h30)) dut_w (
    .CLK(CLK), .RSTb(RSTb), .interrupt(interrupt), .irq(irq), .gie(gie),
    .insn_boundary(insn_boundary), .ack(ack), .reti(reti),
    .int_req(w_int_req), .vector(w_vector), .in_isr(w_in_isr), .active_irq(w_active_irq)
  );

  function automatic vec_t mk(input logic rstb, input logic intr, input logic [3:0] q,
                              input logic g, input logic b, input logic a, input logic r,
                              input logic e_req, input logic [15:0] e_vec,
                              input logic e_isr, input logic [3:0] e_act);
    vec_t v;
    v.rstb = rstb; v.intr = intr; v.irq = q; v.gie = g; v.bnd = b; v.ack = a; v.reti = r;
    v.req = e_req; v.vec = e_vec; v.isr = e_isr; v.act = e_act;
    return v;
  endfunction

  task automatic check(input string tag, input vec_t e);
    logic [5:0] wexp;
    wexp = 6'h30 + e.vec[5:0];
    n_checks++;
    if ({int_req, vector, in_isr, active_irq} !== {e.req, e.vec, e.isr, e.act}) begin
      n_fail++;
      $display("FAIL %s: got int_req=%0b vector=%h in_isr=%0b active_irq=%0d, want int_req=%0b vector=%h in_isr=%0b active_irq=%0d",
               tag, int_req, vector, in_isr, active_irq, e.req, e.vec, e.isr, e.act);
    end
    n_checks++;
    if ({w_int_req, w_vector, w_in_isr, w_active_irq} !== {e.req, wexp, e.isr, e.act}) begin
      n_fail++;
      $display("FAIL %s_wrap: got int_req=%0b vector=%h in_isr=%0b active_irq=%0d, want int_req=%0b vector=%h in_isr=%0b active_irq=%0d",
               tag, w_int_req, w_vector, w_in_isr, w_active_irq, e.req, wexp, e.isr, e.act);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge CLK);
    RSTb = v.rstb; interrupt = v.intr; irq = v.irq; gie = v.gie;
    insn_boundary = v.bnd; ack = v.ack; reti = v.reti;
    sb.push_back(v);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check(tag, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTb = 1'b0; interrupt = 1'b0; irq = 4'd0; gie = 1'b0;
    insn_boundary = 1'b0; ack = 1'b0; reti = 1'b0;

    //                rstb intr irq   gie bnd ack reti  req vec      isr act
    tbl.push_back(mk(0, 0, 4'd0, 0, 0, 0, 0,  0, 16'h0000, 0, 4'd0)); // reset
    tbl.push_back(mk(1, 0, 4'd0, 0, 0, 0, 0,  0, 16'h0000, 0, 4'd0));
    tbl.push_back(mk(1, 1, 4'd3, 1, 0, 0, 0,  0, 16'h0000, 0, 4'd0)); // ARMED
    tbl.push_back(mk(1, 1, 4'd3, 1, 0, 0, 0,  0, 16'h0000, 0, 4'd0));
    tbl.push_back(mk(1, 1, 4'd3, 1, 1, 0, 0,  1, 16'h000C, 0, 4'd0)); // take irq 3
    tbl.push_back(mk(1, 1, 4'd9, 1, 0, 0, 0,  1, 16'h000C, 0, 4'd0)); // vector held
    tbl.push_back(mk(1, 1, 4'd3, 1, 0, 0, 1,  1, 16'h000C, 0, 4'd0)); // reti in REQ ignored
    tbl.push_back(mk(1, 1, 4'd5, 1, 0, 1, 0,  0, 16'h000C, 1, 4'd3)); // ack + irq change
    tbl.push_back(mk(1, 0, 4'd0, 1, 0, 0, 0,  0, 16'h000C, 1, 4'd3));
    tbl.push_back(mk(1, 0, 4'd0, 1, 0, 0, 1,  0, 16'h0000, 0, 4'd0)); // reti -> IDLE
    tbl.push_back(mk(1, 0, 4'd0, 1, 0, 1, 0,  0, 16'h0000, 0, 4'd0)); // ack in IDLE ignored
    tbl.push_back(mk(1, 1, 4'd6, 1, 0, 0, 0,  0, 16'h0000, 0, 4'd0)); // withdrawal
    tbl.push_back(mk(1, 0, 4'd6, 1, 0, 0, 0,  0, 16'h0000, 0, 4'd0));
    tbl.push_back(mk(1, 0, 4'd6, 1, 1, 0, 0,  0, 16'h0000, 0, 4'd0));
    tbl.push_back(mk(1, 1, 4'd2, 1, 0, 0, 0,  0, 16'h0000, 0, 4'd0)); // withdrawal via irq=0
    tbl.push_back(mk(1, 1, 4'd0, 1, 1, 0, 0,  0, 16'h0000, 0, 4'd0));
    tbl.push_back(mk(1, 0, 4'd0, 1, 0, 0, 0,  0, 16'h0000, 0, 4'd0));
    tbl.push_back(mk(1, 1, 4'd7, 1, 0, 0, 0,  0, 16'h0000, 0, 4'd0)); // reti in ARMED ignored
    tbl.push_back(mk(1, 1, 4'd7, 1, 0, 0, 1,  0, 16'h0000, 0, 4'd0));
    tbl.push_back(mk(1, 1, 4'd7, 1, 1, 0, 0,  1, 16'h001C, 0, 4'd0));
    tbl.push_back(mk(1, 0, 4'd0, 1, 0, 1, 0,  0, 16'h001C, 1, 4'd7));
    tbl.push_back(mk(1, 0, 4'd0, 1, 0, 0, 1,  0, 16'h0000, 0, 4'd0));
    tbl.push_back(mk(1, 1, 4'hF, 1, 0, 0, 0,  0, 16'h0000, 0, 4'd0)); // lowest priority 15
    tbl.push_back(mk(1, 1, 4'hF, 1, 1, 0, 0,  1, 16'h003C, 0, 4'd0));
    tbl.push_back(mk(1, 0, 4'd0, 1, 0, 1, 0,  0, 16'h003C, 1, 4'hF));
    tbl.push_back(mk(1, 0, 4'd0, 1, 0, 0, 1,  0, 16'h0000, 0, 4'd0));
    tbl.push_back(mk(1, 1, 4'd2, 1, 0, 0, 0,  0, 16'h0000, 0, 4'd0)); // same-priority block
    tbl.push_back(mk(1, 1, 4'd2, 1, 1, 0, 0,  1, 16'h0008, 0, 4'd0));
    tbl.push_back(mk(1, 0, 4'd0, 1, 0, 1, 0,  0, 16'h0008, 1, 4'd2));
    tbl.push_back(mk(1, 1, 4'd2, 1, 1, 0, 0,  0, 16'h0008, 1, 4'd2));
    tbl.push_back(mk(1, 1, 4'd5, 1, 1, 0, 0,  0, 16'h0008, 1, 4'd2));
    tbl.push_back(mk(1, 0, 4'd0, 1, 0, 0, 1,  0, 16'h0000, 0, 4'd0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

    // gie low: boundaries must never produce a request
    for (int i = 0; i < 20; i++)
      apply(mk(1, 1, 4'd1, 0, i[0], 0, 0, 0, 16'h0000, 0, 4'd0), $sformatf("gie_off%0d", i));
    apply(mk(1, 1, 4'd1, 1, 0, 0, 0, 0, 16'h0000, 0, 4'd0), "gie_arm");
    apply(mk(1, 1, 4'd1, 1, 1, 0, 0, 1, 16'h0004, 0, 4'd0), "gie_take");
    apply(mk(1, 0, 4'd0, 1, 0, 1, 0, 0, 16'h0004, 1, 4'd1), "gie_ack");
    apply(mk(1, 0, 4'd0, 1, 0, 0, 1, 0, 16'h0000, 0, 4'd0), "gie_reti");

    // reset asserted between edges while int_req is high
    apply(mk(1, 1, 4'd3, 1, 0, 0, 0, 0, 16'h0000, 0, 4'd0), "rst_arm");
    apply(mk(1, 1, 4'd3, 1, 1, 0, 0, 1, 16'h000C, 0, 4'd0), "rst_req");
    @(negedge CLK);
    #2;
    RSTb = 1'b0; interrupt = 1'b0; insn_boundary = 1'b0;
    #1;
    check("rst_async", mk(0, 0, 4'd0, 0, 0, 0, 0, 0, 16'h0000, 0, 4'd0));
    apply(mk(0, 0, 4'd0, 1, 0, 0, 0, 0, 16'h0000, 0, 4'd0), "rst_hold");
    apply(mk(1, 0, 4'd0, 1, 0, 1, 0, 0, 16'h0000, 0, 4'd0), "rst_stale_ack");
    apply(mk(1, 0, 4'd0, 1, 0, 0, 0, 0, 16'h0000, 0, 4'd0), "rst_idle");

    // preemption by a higher-priority IRQ while a handler runs
    apply(mk(1, 1, 4'd4, 1, 0, 0, 0, 0, 16'h0000, 0, 4'd0), "nest_arm");
    apply(mk(1, 1, 4'd4, 1, 1, 0, 0, 1, 16'h0010, 0, 4'd0), "nest_req4");
    apply(mk(1, 0, 4'd0, 1, 0, 1, 0, 0, 16'h0010, 1, 4'd4), "nest_isr4");
`ifdef INTSEQ_NEST_EN
    apply(mk(1, 1, 4'd2, 1, 1, 0, 0, 1, 16'h0008, 1, 4'd4), "nest_req2");
    apply(mk(1, 0, 4'd0, 1, 0, 1, 0, 0, 16'h0008, 1, 4'd2), "nest_isr2");
    apply(mk(1, 1, 4'd1, 1, 1, 0, 0, 0, 16'h0008, 1, 4'd2), "nest_full");
    apply(mk(1, 0, 4'd0, 1, 0, 0, 1, 0, 16'h0008, 1, 4'd4), "nest_pop");
    apply(mk(1, 0, 4'd0, 1, 0, 0, 1, 0, 16'h0000, 0, 4'd0), "nest_exit");
`else
    apply(mk(1, 1, 4'd2, 1, 1, 0, 0, 0, 16'h0010, 1, 4'd4), "nest_req2");
    apply(mk(1, 0, 4'd0, 1, 0, 1, 0, 0, 16'h0010, 1, 4'd4), "nest_isr2");
    apply(mk(1, 1, 4'd1, 1, 1, 0, 0, 0, 16'h0010, 1, 4'd4), "nest_full");
    apply(mk(1, 0, 4'd0, 1, 0, 0, 1, 0, 16'h0000, 0, 4'd0), "nest_pop");
    apply(mk(1, 0, 4'd0, 1, 0, 0, 1, 0, 16'h0000, 0, 4'd0), "nest_exit");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
